zion_basic_circuit_lib_skid_buf: RTL and testbench

Two-entry registered skid buffer that cuts both the forward path (valid/data) and the backward path (ready) of a valid/ready stream with full throughput. It is the flow-controlled counterpart of the plain pipeline DFF: where a DFF only retimes data forward, this block also registers the returning ready, so a consumer's backpressure reaches the producer one cycle later without dropping data. It sits between any two pipeline stages whose ready path fails timing.

---
 rtl/zion_basic_circuit_lib_skid_buf.sv | 170 +++++++++++++++++
 tb/tb_zion_basic_circuit_lib_skid_buf.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zion_basic_circuit_lib_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : zion_basic_circuit_lib_skid_buf
// Description : Two-entry registered skid buffer for a valid/ready stream.
//               Both the forward path (oVld/oDat) and the backward path
//               (iRdy) come straight from flops. Full throughput is kept
//               with one beat of skid storage. That beat absorbs the
//               transfer that is already in flight when downstream
//               backpressure arrives.
// Ports       : clk   - clock, all state changes on the rising edge
//               rst_n - asynchronous reset, active low
//               iVld  - upstream data valid
//               iRdy  - upstream ready (flop output)
//               iDat  - upstream data, WIDTH bits
//               oVld  - downstream data valid (flop output)
//               oRdy  - downstream ready
//               oDat  - downstream data (main register), WIDTH bits
//               oCnt  - occupancy: 0, 1 or 2 beats held
// Revision    : 1.0 - initial release
// ============================================================================
module zion_basic_circuit_lib_skid_buf #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iVld,
    output logic             iRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             oRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oCnt
);

    // ------------------------------------------------------------------------
    // Parameter sanity check
    // ------------------------------------------------------------------------
    if (WIDTH < 1) begin : g_width_chk
`ifdef CHECK_ERR_EXIT
        $fatal(0, "Parameter Error: SkidBuf WIDTH must be >= 1!!");
`else
        $error("Parameter Error: SkidBuf WIDTH must be >= 1!!");
`endif
    end

    // ------------------------------------------------------------------------
    // State encoding (the encoding equals the occupancy)
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_irdy;
    logic             r_ovld;

    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;

    assign w_xfer_in  = iVld & r_irdy;
    assign w_xfer_out = r_ovld & oRdy;

    // ------------------------------------------------------------------------
    // Next-state and load decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                // oVld is low here, so no transfer out can occur.
                if (w_xfer_in) begin
                    w_ld_main_in = 1'b1;
                    w_state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_xfer_in && w_xfer_out) begin
                    // The new beat replaces the departing one.
                    w_ld_main_in = 1'b1;
                end else if (w_xfer_in) begin
                    // Downstream stalled while a beat was in flight; park it.
                    w_ld_skid   = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_xfer_out) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // iRdy is low here, so no transfer in can occur.
                if (w_xfer_out) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nxt    = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and handshake flops
    // ------------------------------------------------------------------------
    // iRdy and oVld are registered copies of the next-state decode. They
    // stay aligned with r_state, and no combinational path runs from oRdy
    // to iRdy. iRdy resets low and first rises on the edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_irdy  <= 1'b0;
            r_ovld  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irdy  <= (w_state_nxt != ST_FULL);
            r_ovld  <= (w_state_nxt != ST_EMPTY);
        end
    end

    // ------------------------------------------------------------------------
    // Data registers (written only on a load, otherwise hold)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= INI_DATA;
        end else if (w_ld_main_in) begin
            r_main <= iDat;
        end else if (w_ld_main_skid) begin
            r_main <= r_skid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_ld_skid) begin
            r_skid <= iDat;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        oCnt = 2'd0;
        case (r_state)
            ST_EMPTY: oCnt = 2'd0;
            ST_BUSY:  oCnt = 2'd1;
            ST_FULL:  oCnt = 2'd2;
            default:  oCnt = 2'd0;
        endcase
    end

    assign iRdy = r_irdy;
    assign oVld = r_ovld;
    assign oDat = r_main;

endmodule
`default_nettype wire

// File: tb/tb_zion_basic_circuit_lib_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_zion_basic_circuit_lib_skid_buf
// Description : Self-checking bench for the two-entry skid buffer. Accepted
//               beats go into a scoreboard queue and are compared when they
//               leave the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zion_basic_circuit_lib_skid_buf;

    localparam int         WIDTH    = 8;
    localparam logic [7:0] INI_DATA = 8'hA5;

    logic             clk;
    logic             rst_n;
    logic             iVld;
    logic             iRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             oRdy;
    logic [WIDTH-1:0] oDat;
    logic [1:0]       oCnt;

    int n_cmp;
    int n_err;

    logic [7:0] sb_q[$];
    logic [7:0] exp_dat;

    // Handshake observations for the current cycle
    logic       obs_in;
    logic       obs_out;
    logic [7:0] obs_dat;
    logic [1:0] obs_cnt;

    zion_basic_circuit_lib_skid_buf #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iVld  (iVld),
        .iRdy  (iRdy),
        .iDat  (iDat),
        .oVld  (oVld),
        .oRdy  (oRdy),
        .oDat  (oDat),
        .oCnt  (oCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a falling edge, once the inputs are set. It records
    // which transfers the coming rising edge will perform.
    task automatic sample();
        #1;
        obs_in  = iVld & iRdy;
        obs_out = oVld & oRdy;
        obs_dat = oDat;
        obs_cnt = oCnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iVld  = 1'b1;
        iDat  = 8'h55;
        oRdy  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (oVld !== 1'b0) begin n_err++; $display("FAIL reset_ovld got=%b exp=0", oVld); end
        n_cmp++;
        if (oDat !== INI_DATA) begin n_err++; $display("FAIL reset_odat got=%h exp=%h", oDat, INI_DATA); end
        n_cmp++;
        if (iRdy !== 1'b0) begin n_err++; $display("FAIL reset_irdy got=%b exp=0", iRdy); end
        n_cmp++;
        if (oCnt !== 2'd0) begin n_err++; $display("FAIL reset_ocnt got=%0d exp=0", oCnt); end
        // Release between edges; iRdy must stay low until the next rising edge.
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (iRdy !== 1'b0) begin n_err++; $display("FAIL release_irdy_early got=%b exp=0", iRdy); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (iRdy !== 1'b1) begin n_err++; $display("FAIL release_irdy_after_edge got=%b exp=1", iRdy); end
        n_cmp++;
        if (oVld !== 1'b0 || oCnt !== 2'd0) begin
            n_err++; $display("FAIL release_no_accept got_vld=%b got_cnt=%0d exp_vld=0 exp_cnt=0", oVld, oCnt);
        end
        iVld = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        int idx       = 0;
        int n_out     = 0;
        int first_in  = -1;
        int first_out = -1;
        bit done      = 0;
        oRdy = 1'b1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            iVld = (idx < 16);
            iDat = 8'(idx + 1);
            sample();
            if (idx < 16) begin
                n_cmp++;
                if (iRdy !== 1'b1) begin n_err++; $display("FAIL stream_irdy cyc=%0d got=%b exp=1", cyc, iRdy); end
            end
            if (first_out >= 0 && n_out < 16) begin
                n_cmp++;
                if (obs_out !== 1'b1) begin n_err++; $display("FAIL stream_gap cyc=%0d got_out=%b exp=1", cyc, obs_out); end
            end
            if (obs_out) begin
                if (first_out < 0) first_out = cyc;
                exp_dat = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                n_cmp++;
                if (obs_dat !== exp_dat) begin n_err++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, obs_dat, exp_dat); end
                n_out++;
            end
            if (obs_in) begin
                if (first_in < 0) first_in = cyc;
                sb_q.push_back(iDat);
                idx++;
            end
            @(negedge clk);
            if (n_out == 16 && sb_q.size() == 0) done = 1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL stream_timeout got_out=%0d exp_out=16", n_out); end
        n_cmp++;
        if (first_out - first_in != 1) begin
            n_err++; $display("FAIL stream_latency got=%0d exp=1", first_out - first_in);
        end
        iVld = 1'b0;
    endtask

    task automatic test_skid();
        bit sent22 = 0;
        bit done   = 0;
        // Cycle A: 0x20 presented while downstream stalls; buffer is empty.
        iVld = 1'b1; iDat = 8'h20; oRdy = 1'b0;
        sample();
        n_cmp++;
        if (obs_in !== 1'b1 || obs_cnt !== 2'd0) begin
            n_err++; $display("FAIL skid_accept20 got_in=%b got_cnt=%0d exp_in=1 exp_cnt=0", obs_in, obs_cnt);
        end
        if (obs_in) sb_q.push_back(iDat);
        @(negedge clk);
        // Cycle B: 0x21 is still accepted and goes to the skid register.
        iDat = 8'h21;
        sample();
        n_cmp++;
        if (obs_in !== 1'b1 || obs_cnt !== 2'd1 || obs_dat !== 8'h20) begin
            n_err++; $display("FAIL skid_accept21 got_in=%b got_cnt=%0d got_dat=%h exp_in=1 exp_cnt=1 exp_dat=20", obs_in, obs_cnt, obs_dat);
        end
        if (obs_in) sb_q.push_back(iDat);
        @(negedge clk);
        // Cycles C1/C2: buffer full, 0x22 must be held upstream.
        iDat = 8'h22;
        for (int k = 0; k < 2; k++) begin
            sample();
            n_cmp++;
            if (iRdy !== 1'b0 || obs_cnt !== 2'd2 || obs_dat !== 8'h20 || oVld !== 1'b1) begin
                n_err++; $display("FAIL skid_full k=%0d got_rdy=%b got_cnt=%0d got_dat=%h got_vld=%b exp_rdy=0 exp_cnt=2 exp_dat=20 exp_vld=1",
                                  k, iRdy, obs_cnt, obs_dat, oVld);
            end
            if (obs_in) sb_q.push_back(iDat);
            @(negedge clk);
        end
        // Release backpressure and drain.
        oRdy = 1'b1;
        for (int k = 0; k < 10 && !done; k++) begin
            iVld = !sent22;
            sample();
            if (k == 0) begin
                n_cmp++;
                if (iRdy !== 1'b0) begin n_err++; $display("FAIL skid_release_irdy0 got=%b exp=0", iRdy); end
            end
            if (k == 1) begin
                n_cmp++;
                if (iRdy !== 1'b1 || obs_dat !== 8'h21) begin
                    n_err++; $display("FAIL skid_release_irdy1 got_rdy=%b got_dat=%h exp_rdy=1 exp_dat=21", iRdy, obs_dat);
                end
            end
            if (obs_out) begin
                exp_dat = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                n_cmp++;
                if (obs_dat !== exp_dat) begin n_err++; $display("FAIL skid_data k=%0d got=%h exp=%h", k, obs_dat, exp_dat); end
            end
            if (obs_in) begin sb_q.push_back(iDat); sent22 = 1; end
            @(negedge clk);
            if (sent22 && sb_q.size() == 0) done = 1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL skid_timeout got_left=%0d exp_left=0", sb_q.size()); end
        iVld = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_random();
        bit         stall_prev = 0;
        logic [7:0] dat_prev   = '0;
        bit         done       = 0;
        iVld = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Upstream keeps iVld/iDat stable until its beat is accepted.
            if (!iVld) begin
                iVld = ($urandom_range(0, 9) < 6);
                iDat = 8'($urandom);
            end
            oRdy = ($urandom_range(0, 9) < 6);
            sample();
            n_cmp++;
            if (obs_cnt !== 2'(sb_q.size())) begin
                n_err++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, obs_cnt, sb_q.size());
            end
            if (stall_prev) begin
                n_cmp++;
                if (oVld !== 1'b1 || obs_dat !== dat_prev) begin
                    n_err++; $display("FAIL rand_stable cyc=%0d got_vld=%b got_dat=%h exp_vld=1 exp_dat=%h", cyc, oVld, obs_dat, dat_prev);
                end
            end
            if (obs_out) begin
                exp_dat = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                n_cmp++;
                if (obs_dat !== exp_dat) begin n_err++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, obs_dat, exp_dat); end
            end
            if (obs_in) sb_q.push_back(iDat);
            stall_prev = oVld & !oRdy;
            dat_prev   = obs_dat;
            @(negedge clk);
            if (obs_in) iVld = 1'b0;
        end
        // Drain what remains.
        iVld = 1'b0;
        oRdy = 1'b1;
        for (int k = 0; k < 10 && !done; k++) begin
            sample();
            if (obs_out) begin
                exp_dat = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                n_cmp++;
                if (obs_dat !== exp_dat) begin n_err++; $display("FAIL rand_drain k=%0d got=%h exp=%h", k, obs_dat, exp_dat); end
            end
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && oVld === 1'b0) done = 1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL rand_drain_timeout got_left=%0d exp_left=0", sb_q.size()); end
    endtask

    task automatic test_mid_reset();
        bit seen_bad = 0;
        bit got40    = 0;
        // Fill the buffer with 0x30 and 0x31 under backpressure.
        oRdy = 1'b0;
        iVld = 1'b1; iDat = 8'h30;
        sample(); if (obs_in) sb_q.push_back(iDat);
        @(negedge clk);
        iDat = 8'h31;
        sample(); if (obs_in) sb_q.push_back(iDat);
        @(negedge clk);
        iVld = 1'b0;
        #1;
        n_cmp++;
        if (oCnt !== 2'd2 || oDat !== 8'h30) begin
            n_err++; $display("FAIL midrst_fill got_cnt=%0d got_dat=%h exp_cnt=2 exp_dat=30", oCnt, oDat);
        end
        // Pulse reset between edges; outputs must clear without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (oVld !== 1'b0 || oCnt !== 2'd0 || oDat !== INI_DATA || iRdy !== 1'b0) begin
            n_err++; $display("FAIL midrst_async got_vld=%b got_cnt=%0d got_dat=%h got_rdy=%b exp_vld=0 exp_cnt=0 exp_dat=%h exp_rdy=0",
                              oVld, oCnt, oDat, iRdy, INI_DATA);
        end
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        oRdy = 1'b1;
        @(negedge clk);
        // Send 0x40; only it may ever appear.
        for (int k = 0; k < 8; k++) begin
            iVld = !got40 && (k >= 2);
            iDat = 8'h40;
            sample();
            if (obs_out && obs_dat !== 8'h40) seen_bad = 1;
            if (obs_in) got40 = 1;
            if (obs_out) begin
                n_cmp++;
                if (obs_dat !== 8'h40) begin n_err++; $display("FAIL midrst_out k=%0d got=%h exp=40", k, obs_dat); end
            end
            @(negedge clk);
        end
        iVld = 1'b0;
        n_cmp++;
        if (seen_bad || !got40) begin
            n_err++; $display("FAIL midrst_discard got_bad=%b got_sent=%b exp_bad=0 exp_sent=1", seen_bad, got40);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        iVld  = 1'b0;
        iDat  = '0;
        oRdy  = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_skid();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
